// File: rtl/ssd_scan_driver_if.sv
`default_nettype none
// ============================================================================
//  Module      : ssd_scan_driver_if
//  Description : Bundles the display-content inputs and the multiplexed
//                seven-segment outputs of ssd_scan_driver.
//  Revision    : 1.0  initial release
// ============================================================================
interface ssd_scan_driver_if;
  logic [19:0] code;        // four 5-bit symbols, [19:15] = digit 0 (leftmost)
  logic [3:0]  blink_mask;  // bit 3 = digit 0 ... bit 0 = digit 3
  logic [3:0]  dp_mask;     // same bit order as blink_mask
  logic [3:0]  an;          // active-low anodes, an[3] = digit 0
  logic [6:0]  seg;         // active-low segments g,f,e,d,c,b,a
  logic        dp_n;        // active-low decimal point
  logic        frame_tick;  // one-cycle pulse on shadow reload

  // Content source side
  modport master (
    output code, blink_mask, dp_mask,
    input  an, seg, dp_n, frame_tick
  );

  // Display driver side
  modport slave (
    input  code, blink_mask, dp_mask,
    output an, seg, dp_n, frame_tick
  );
endinterface
`default_nettype wire

// File: rtl/ssd_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : ssd_scan_driver
//  Description : Four-digit multiplexed seven-segment scan driver with
//                frame-synchronous shadow registers, per-digit blink and
//                decimal-point control, and a symbol decoder.
//  Revision    : 1.0  initial release
// ============================================================================
module ssd_scan_driver #(
  parameter int REFRESH_DIV = 100000,   // clocks each digit stays lit
  parameter int BLINK_DIV   = 50000000  // clocks per blink half-period
) (
  input wire clk,
  input wire rst,
  ssd_scan_driver_if.slave bus
);

  localparam int RCNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BCNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [RCNT_W-1:0] RCNT_MAX = RCNT_W'(REFRESH_DIV - 1);
  localparam logic [BCNT_W-1:0] BCNT_MAX = BCNT_W'(BLINK_DIV - 1);

  localparam logic [19:0] BLANK_CODE = 20'h84210;  // symbol 0x10 in every digit
  localparam logic [6:0]  SEG_OFF    = 7'h7F;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [RCNT_W-1:0] rcnt_q, rcnt_d;
  logic [1:0]        idx_q, idx_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic              blink_phase_q, blink_phase_d;

  logic [19:0]       sh_code_q, sh_code_d;
  logic [3:0]        sh_blink_q, sh_blink_d;
  logic [3:0]        sh_dp_q, sh_dp_d;

  logic [3:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_n_q, dp_n_d;

  logic              scan_tick;
  logic              frame_load;
  logic [1:0]        mask_bit;
  logic [4:0]        active_sym;
  logic              blanked;

  // --------------------------------------------------------------------------
  // Symbol decoder: 0x00-0x0F hex digits, 0x10-0x17 letters/marks, rest blank
  // --------------------------------------------------------------------------
  function automatic logic [6:0] seg_decode(input logic [4:0] sym);
    logic [6:0] s;
    case (sym)
      5'h00: s = 7'h40;
      5'h01: s = 7'h79;
      5'h02: s = 7'h24;
      5'h03: s = 7'h30;
      5'h04: s = 7'h19;
      5'h05: s = 7'h12;
      5'h06: s = 7'h02;
      5'h07: s = 7'h78;
      5'h08: s = 7'h00;
      5'h09: s = 7'h10;
      5'h0A: s = 7'h08;
      5'h0B: s = 7'h03;
      5'h0C: s = 7'h46;
      5'h0D: s = 7'h21;
      5'h0E: s = 7'h06;
      5'h0F: s = 7'h0E;
      5'h10: s = 7'h7F;  // blank
      5'h11: s = 7'h47;  // L
      5'h12: s = 7'h3F;  // -
      5'h13: s = 7'h23;  // o
      5'h14: s = 7'h0C;  // P
      5'h15: s = 7'h2B;  // n
      5'h16: s = 7'h41;  // U
      5'h17: s = 7'h2F;  // r
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // --------------------------------------------------------------------------
  // Scan timing: digit dwell counter, digit index, frame reload strobe
  // --------------------------------------------------------------------------
  assign scan_tick  = (rcnt_q == RCNT_MAX);
  assign frame_load = scan_tick && (idx_q == 2'd3);

  // Next-state for the refresh counter, digit index and blink generator
  always_comb begin
    rcnt_d        = rcnt_q + 1'b1;
    idx_d         = idx_q;
    bcnt_d        = bcnt_q + 1'b1;
    blink_phase_d = blink_phase_q;
    if (scan_tick) begin
      rcnt_d = '0;
      idx_d  = idx_q + 2'd1;
    end
    if (bcnt_q == BCNT_MAX) begin
      bcnt_d        = '0;
      blink_phase_d = ~blink_phase_q;
    end
  end

  // Next-state for the shadow frame: captured only at the frame boundary
  always_comb begin
    sh_code_d  = sh_code_q;
    sh_blink_d = sh_blink_q;
    sh_dp_d    = sh_dp_q;
    if (frame_load) begin
      sh_code_d  = bus.code;
      sh_blink_d = bus.blink_mask;
      sh_dp_d    = bus.dp_mask;
    end
  end

  // --------------------------------------------------------------------------
  // Output formation from the current digit, shadow frame and live blink phase
  // --------------------------------------------------------------------------
  // Mask bit 3 belongs to digit 0, so the bit index is the reversed digit index.
  assign mask_bit = 2'd3 - idx_q;
  assign blanked  = blink_phase_q && sh_blink_q[mask_bit];

  // Pick the active digit's symbol out of the shadow code
  always_comb begin
    active_sym = sh_code_q[19:15];
    case (idx_q)
      2'd0: active_sym = sh_code_q[19:15];
      2'd1: active_sym = sh_code_q[14:10];
      2'd2: active_sym = sh_code_q[9:5];
      2'd3: active_sym = sh_code_q[4:0];
      default: active_sym = sh_code_q[19:15];
    endcase
  end

  // Next values of the registered display outputs
  always_comb begin
    an_d   = ~(4'b1000 >> idx_q);
    seg_d  = seg_decode(active_sym);
    dp_n_d = ~sh_dp_q[mask_bit];
    if (blanked) begin
      seg_d  = SEG_OFF;
      dp_n_d = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  // Counters and blink phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcnt_q        <= '0;
      idx_q         <= 2'd0;
      bcnt_q        <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      rcnt_q        <= rcnt_d;
      idx_q         <= idx_d;
      bcnt_q        <= bcnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  // Shadow frame, reset to an all-blank display
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_code_q  <= BLANK_CODE;
      sh_blink_q <= 4'b0000;
      sh_dp_q    <= 4'b0000;
    end else begin
      sh_code_q  <= sh_code_d;
      sh_blink_q <= sh_blink_d;
      sh_dp_q    <= sh_dp_d;
    end
  end

  // Display outputs, registered so they are glitch-free at the pins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_q   <= 4'hF;
      seg_q  <= SEG_OFF;
      dp_n_q <= 1'b1;
    end else begin
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_n_q <= dp_n_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp_n       = dp_n_q;
  assign bus.frame_tick = frame_load;

endmodule
`default_nettype wire

// File: doc/ssd_scan_driver.md
SSD_SCAN_DRIVER -- requirements
Module: ssd_scan_driver

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, clocks each digit stays lit (legal range >= 2).
REQ-002 SHALL have parameter BLINK_DIV, default 50000000, clocks per blink half-period (legal range >= 2).
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port code  input  20  four 5-bit symbol codes; code[19:15] is digit 0 (leftmost), code[4:0] is digit 3.
REQ-006 SHALL have port blink_mask  input  4  bit 3 = digit 0 ... bit 0 = digit 3; set bit blinks that digit.
REQ-007 SHALL have port dp_mask  input  4  same bit order; set bit lights that digit's decimal point.
REQ-008 SHALL have port an  output  4  active-low anodes; an[3] = digit 0, an[0] = digit 3.
REQ-009 SHALL have port seg  output  7  active-low segments, seg[6:0] = g,f,e,d,c,b,a.
REQ-010 SHALL have port dp_n  output  1  active-low decimal point.
REQ-011 SHALL have port frame_tick  output  1  one-cycle pulse when the shadow frame reloads.

Function
REQ-012 SHALL keep refresh counter rcnt 0..REFRESH_DIV-1, wrapping to 0; scan_tick = (rcnt == REFRESH_DIV-1).
REQ-013 SHALL keep 2-bit digit index idx, incrementing mod 4 on scan_tick; scan order 0,1,2,3,0.
REQ-014 SHALL, on scan_tick with idx == 3, load shadow registers from code, blink_mask and dp_mask, and assert frame_tick for that one cycle.
REQ-015 SHALL drive the display only from the shadow registers; input changes mid-frame have no visible effect until the next frame_tick.
REQ-016 SHALL keep blink counter bcnt 0..BLINK_DIV-1, free-running, independent of the scan, toggling blink_phase on bcnt == BLINK_DIV-1.
REQ-017 SHALL register an, seg and dp_n every clock from the current idx, shadow and blink_phase, so outputs lag idx by exactly 1 clock.
REQ-018 SHALL drive an with only the bit for digit idx low (idx 0 -> 4'b0111, 1 -> 1011, 2 -> 1101, 3 -> 1110).
REQ-019 SHALL decode hex codes 0x00-0x0F to seg: 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E (hex).
REQ-020 SHALL decode symbol codes: 0x10 blank:7F, 0x11 L:47, 0x12 '-':3F, 0x13 o:23, 0x14 P:0C, 0x15 n:2B, 0x16 U:41, 0x17 r:2F; codes 0x18-0x1F SHALL decode to 7F.
REQ-021 SHALL force seg = 7F and dp_n = 1 for the active digit when blink_phase = 1 and its shadow blink bit is set; an is unchanged.
REQ-022 SHALL otherwise drive dp_n = ~(shadow dp bit of the active digit).
REQ-023 SHALL apply blink_phase live (unlatched); a blink edge mid-digit takes effect on the next clock.

Reset
REQ-024 SHALL, while rst = 1, asynchronously force an = 4'hF, seg = 7'h7F, dp_n = 1, frame_tick = 0, rcnt = 0, bcnt = 0, idx = 0, blink_phase = 0.
REQ-025 SHALL reset shadow code to 20'h84210 (all blank), and shadow blink and dp masks to 0.
REQ-026 SHALL, on rst asserted mid-scan, abandon the frame; after release the scan restarts at digit 0 with a blank shadow.

Verification (REFRESH_DIV=4, BLINK_DIV=64)
REQ-027 SHALL check: rst pulse, then release -> reset values during rst; the first clock after release gives an=0111, seg=7F, dp_n=1.
REQ-028 SHALL check: code={0C,11,05,0D} held for 2 frames -> digits show an/seg = 0111/46, 1011/47, 1101/12, 1110/21, each for 4 clocks.
REQ-029 SHALL check: code changed while idx=1 -> remaining digits show old symbols; new symbols appear only after the next frame_tick pulse.
REQ-030 SHALL check: blink_mask=1000, dp_mask=0001 -> digit 0 shows 7F while blink_phase=1 and its symbol otherwise; digit 3 shows dp_n=0 in both phases.
REQ-031 SHALL check: codes 12, 17, 18 and 1F -> seg 3F, 2F, 7F and 7F respectively.
REQ-032 SHALL check: rst asserted while idx=2 -> outputs go to reset values asynchronously, before the next clock edge.
